// File: rtl/ddr_cmd_issuer_pkg.sv
// Shared definitions for the DDR command issuer: app command codes, FIFO command type
// encodings, FSM state encodings and the read-credit helper.
package ddr_cmd_issuer_pkg;

  localparam logic [2:0] APP_CMD_WR  = 3'b000;
  localparam logic [2:0] APP_CMD_RD  = 3'b001;
  localparam logic       CMD_TYPE_WR = 1'b1;
  localparam logic       CMD_TYPE_RD = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_LOAD     = 3'd2,
    ST_ISSUE_WR = 3'd3,
    ST_ISSUE_RD = 3'd4
  } state_e;

  // True when a read of burst+1 beats still fits under the in-flight beat ceiling.
  function automatic logic credit_ok(input logic [31:0] outstanding,
                                     input logic [31:0] burst,
                                     input logic [31:0] max_beats);
    return (outstanding + burst + 32'd1) <= max_beats;
  endfunction

endpackage

// File: rtl/ddr_cmd_issuer_rd_track.sv
// Read-beat bookkeeping: outstanding beat counter, FIFO of per-command burst lengths,
// registered read-data forwarding with rd_last on the final beat of each command.
module ddr_cmd_issuer_rd_track
  import ddr_cmd_issuer_pkg::*;
#(
  parameter int BURST_W      = 6,
  parameter int DATA_W       = 128,
  parameter int MAX_RD_BEATS = 64,
  parameter int CNT_W        = $clog2(MAX_RD_BEATS + 1)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               rd_cmd_acc,
  input  logic [BURST_W-1:0] rd_burst,
  input  logic               app_rdata_valid,
  input  logic [DATA_W-1:0]  app_rdata,
  output logic               rd_valid,
  output logic [DATA_W-1:0]  rd_data,
  output logic               rd_last,
  output logic [CNT_W-1:0]   outstanding
);

  localparam int PTR_W = (MAX_RD_BEATS > 1) ? $clog2(MAX_RD_BEATS) : 1;

  logic [BURST_W-1:0] len_mem [MAX_RD_BEATS];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [BURST_W-1:0] beat_q, beat_d;
  logic [CNT_W-1:0]   outstanding_q, outstanding_d;
  logic               beat_ok, last_beat;
  logic               rd_valid_q, rd_last_q;
  logic [DATA_W-1:0]  rd_data_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_RD_BEATS - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    // A beat with nothing outstanding is a protocol error and is not counted.
    beat_ok       = app_rdata_valid && (outstanding_q != '0);
    last_beat     = beat_ok && (beat_q == len_mem[rd_ptr_q]);
    outstanding_d = outstanding_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    beat_d        = beat_q;
    if (rd_cmd_acc) begin
      outstanding_d = outstanding_d + CNT_W'(rd_burst) + CNT_W'(1);
      wr_ptr_d      = ptr_inc(wr_ptr_q);
    end
    if (beat_ok) begin
      outstanding_d = outstanding_d - CNT_W'(1);
      if (last_beat) begin
        beat_d   = '0;
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
        beat_d = beat_q + BURST_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rd_cmd_acc) len_mem[wr_ptr_q] <= rd_burst;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      outstanding_q <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      beat_q        <= '0;
      rd_valid_q    <= 1'b0;
      rd_data_q     <= '0;
      rd_last_q     <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      beat_q        <= beat_d;
      rd_valid_q    <= app_rdata_valid;
      rd_data_q     <= app_rdata;
      rd_last_q     <= last_beat;
    end
  end

  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
  assign rd_last     = rd_last_q;
  assign outstanding = outstanding_q;

endmodule

// File: rtl/ddr_cmd_issuer.sv
// Pops command FIFO entries and drives the DDR3 app_* user interface; forwards read data.
// Optional statistics counters are built when DDR_CMD_ISSUER_STAT_EN is defined.
module ddr_cmd_issuer
  import ddr_cmd_issuer_pkg::*;
#(
  parameter int ADDR_W       = 27,
  parameter int DATA_W       = 128,
  parameter int MASK_W       = 16,
  parameter int BURST_W      = 6,
  parameter int MAX_RD_BEATS = 64
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               calib_done,
  output logic               fifo_pop_valid,
  input  logic               fifo_pop_ready,
  input  logic               fifo_cmd_type,
  input  logic [ADDR_W-1:0]  fifo_addr,
  input  logic [BURST_W-1:0] fifo_burst_cnt,
  input  logic [DATA_W-1:0]  fifo_wt_data,
  input  logic [MASK_W-1:0]  fifo_wt_mask,
  output logic [2:0]         app_cmd,
  output logic               app_cmd_en,
  input  logic               app_cmd_rdy,
  output logic [ADDR_W-1:0]  app_addr,
  output logic [BURST_W-1:0] app_burst_number,
  output logic               app_wdata_en,
  input  logic               app_wdata_rdy,
  output logic [DATA_W-1:0]  app_wdata,
  output logic [MASK_W-1:0]  app_wdata_mask,
  output logic               app_wdata_end,
  input  logic               app_rdata_valid,
  input  logic [DATA_W-1:0]  app_rdata,
  output logic               rd_valid,
  output logic [DATA_W-1:0]  rd_data,
  output logic               rd_last,
  output logic               busy
`ifdef DDR_CMD_ISSUER_STAT_EN
  ,
  output logic [31:0]        stat_wr_cnt,
  output logic [31:0]        stat_rd_cnt,
  output logic [31:0]        stat_stall_cnt
`endif
);

  localparam int CNT_W = $clog2(MAX_RD_BEATS + 1);

  state_e             state_q;
  logic               pop_valid_q;
  logic [2:0]         cmd_q;
  logic               cmd_en_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [BURST_W-1:0] burst_q;
  logic               wdata_en_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [MASK_W-1:0]  mask_q;
  logic [CNT_W-1:0]   rd_outstanding;
  logic               rd_acc, wr_acc;

  assign rd_acc = (state_q == ST_ISSUE_RD) && cmd_en_q && app_cmd_rdy;
  assign wr_acc = (state_q == ST_ISSUE_WR) && cmd_en_q && app_cmd_rdy;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      pop_valid_q <= 1'b0;
      cmd_q       <= '0;
      cmd_en_q    <= 1'b0;
      addr_q      <= '0;
      burst_q     <= '0;
      wdata_en_q  <= 1'b0;
      wdata_q     <= '0;
      mask_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (calib_done) begin
            state_q     <= ST_FETCH;
            pop_valid_q <= 1'b1;
          end
        end
        ST_FETCH: begin
          // A pop that coincides with calib_done dropping still has to be consumed.
          if (fifo_pop_ready) begin
            state_q     <= ST_LOAD;
            pop_valid_q <= 1'b0;
          end else if (!calib_done) begin
            state_q     <= ST_IDLE;
            pop_valid_q <= 1'b0;
          end
        end
        ST_LOAD: begin
          addr_q <= fifo_addr;
          case (fifo_cmd_type)
            CMD_TYPE_WR: begin
              cmd_q      <= APP_CMD_WR;
              burst_q    <= '0;
              wdata_q    <= fifo_wt_data;
              mask_q     <= fifo_wt_mask;
              cmd_en_q   <= 1'b1;
              wdata_en_q <= 1'b1;
              state_q    <= ST_ISSUE_WR;
            end
            CMD_TYPE_RD: begin
              cmd_q    <= APP_CMD_RD;
              burst_q  <= fifo_burst_cnt;
              cmd_en_q <= credit_ok(32'(rd_outstanding), 32'(fifo_burst_cnt),
                                    32'(MAX_RD_BEATS));
              state_q  <= ST_ISSUE_RD;
            end
            default: state_q <= ST_IDLE;
          endcase
        end
        ST_ISSUE_WR: begin
          if (cmd_en_q && app_cmd_rdy) cmd_en_q <= 1'b0;
          if (wdata_en_q && app_wdata_rdy) wdata_en_q <= 1'b0;
          if ((!cmd_en_q || app_cmd_rdy) && (!wdata_en_q || app_wdata_rdy)) begin
            state_q     <= calib_done ? ST_FETCH : ST_IDLE;
            pop_valid_q <= calib_done;
          end
        end
        ST_ISSUE_RD: begin
          // Outstanding only shrinks while waiting here, so a raised cmd_en never drops early.
          if (rd_acc) begin
            cmd_en_q    <= 1'b0;
            state_q     <= calib_done ? ST_FETCH : ST_IDLE;
            pop_valid_q <= calib_done;
          end else begin
            cmd_en_q <= credit_ok(32'(rd_outstanding), 32'(burst_q), 32'(MAX_RD_BEATS));
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          pop_valid_q <= 1'b0;
          cmd_en_q    <= 1'b0;
          wdata_en_q  <= 1'b0;
        end
      endcase
    end
  end

  ddr_cmd_issuer_rd_track #(
    .BURST_W      (BURST_W),
    .DATA_W       (DATA_W),
    .MAX_RD_BEATS (MAX_RD_BEATS),
    .CNT_W        (CNT_W)
  ) u_rd_track (
    .clk             (clk),
    .rstn            (rstn),
    .rd_cmd_acc      (rd_acc),
    .rd_burst        (burst_q),
    .app_rdata_valid (app_rdata_valid),
    .app_rdata       (app_rdata),
    .rd_valid        (rd_valid),
    .rd_data         (rd_data),
    .rd_last         (rd_last),
    .outstanding     (rd_outstanding)
  );

  assign fifo_pop_valid   = pop_valid_q;
  assign app_cmd          = cmd_q;
  assign app_cmd_en       = cmd_en_q;
  assign app_addr         = addr_q;
  assign app_burst_number = burst_q;
  assign app_wdata_en     = wdata_en_q;
  assign app_wdata        = wdata_q;
  assign app_wdata_mask   = mask_q;
  assign app_wdata_end    = wdata_en_q;
  assign busy             = (state_q != ST_IDLE) || (rd_outstanding != '0);

`ifdef DDR_CMD_ISSUER_STAT_EN
  logic [31:0] stat_wr_q, stat_rd_q, stat_stall_q;
  logic        stall;

  // Stall covers both an unready IP and a read held back for lack of beat credit.
  assign stall = ((state_q == ST_ISSUE_WR) || (state_q == ST_ISSUE_RD)) &&
                 ((cmd_en_q && !app_cmd_rdy) || ((state_q == ST_ISSUE_RD) && !cmd_en_q));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_wr_q    <= '0;
      stat_rd_q    <= '0;
      stat_stall_q <= '0;
    end else begin
      if (wr_acc) stat_wr_q <= stat_wr_q + 32'd1;
      if (rd_acc) stat_rd_q <= stat_rd_q + 32'd1;
      if (stall)  stat_stall_q <= stat_stall_q + 32'd1;
    end
  end

  assign stat_wr_cnt    = stat_wr_q;
  assign stat_rd_cnt    = stat_rd_q;
  assign stat_stall_cnt = stat_stall_q;
`else
  logic unused_wr_acc;
  assign unused_wr_acc = wr_acc;
`endif

endmodule

// File: tb/tb_ddr_cmd_issuer.sv
// Directed bench for ddr_cmd_issuer with a behavioural command FIFO; MAX_RD_BEATS=16.
module tb_ddr_cmd_issuer;

  localparam int ADDR_W = 27;
  localparam int DATA_W = 128;
  localparam int MASK_W = 16;
  localparam int BURST_W = 6;
  localparam int MAXB = 16;

  logic               clk = 1'b0;
  logic               rstn;
  logic               calib_done;
  logic               fifo_pop_valid;
  logic               fifo_pop_ready;
  logic               fifo_cmd_type = 1'b0;
  logic [ADDR_W-1:0]  fifo_addr = '0;
  logic [BURST_W-1:0] fifo_burst_cnt = '0;
  logic [DATA_W-1:0]  fifo_wt_data = '0;
  logic [MASK_W-1:0]  fifo_wt_mask = '0;
  logic [2:0]         app_cmd;
  logic               app_cmd_en;
  logic               app_cmd_rdy;
  logic [ADDR_W-1:0]  app_addr;
  logic [BURST_W-1:0] app_burst_number;
  logic               app_wdata_en;
  logic               app_wdata_rdy;
  logic [DATA_W-1:0]  app_wdata;
  logic [MASK_W-1:0]  app_wdata_mask;
  logic               app_wdata_end;
  logic               app_rdata_valid;
  logic [DATA_W-1:0]  app_rdata;
  logic               rd_valid;
  logic [DATA_W-1:0]  rd_data;
  logic               rd_last;
  logic               busy;
`ifdef DDR_CMD_ISSUER_STAT_EN
  logic [31:0]        stat_wr_cnt, stat_rd_cnt, stat_stall_cnt;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ddr_cmd_issuer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .BURST_W(BURST_W), .MAX_RD_BEATS(MAXB)
  ) u_dut (
    .clk(clk), .rstn(rstn), .calib_done(calib_done),
    .fifo_pop_valid(fifo_pop_valid), .fifo_pop_ready(fifo_pop_ready),
    .fifo_cmd_type(fifo_cmd_type), .fifo_addr(fifo_addr), .fifo_burst_cnt(fifo_burst_cnt),
    .fifo_wt_data(fifo_wt_data), .fifo_wt_mask(fifo_wt_mask),
    .app_cmd(app_cmd), .app_cmd_en(app_cmd_en), .app_cmd_rdy(app_cmd_rdy),
    .app_addr(app_addr), .app_burst_number(app_burst_number),
    .app_wdata_en(app_wdata_en), .app_wdata_rdy(app_wdata_rdy), .app_wdata(app_wdata),
    .app_wdata_mask(app_wdata_mask), .app_wdata_end(app_wdata_end),
    .app_rdata_valid(app_rdata_valid), .app_rdata(app_rdata),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .busy(busy)
`ifdef DDR_CMD_ISSUER_STAT_EN
    , .stat_wr_cnt(stat_wr_cnt), .stat_rd_cnt(stat_rd_cnt), .stat_stall_cnt(stat_stall_cnt)
`endif
  );

  // Command FIFO model: Q presented on the cycle after the pop handshake.
  logic               m_type  [16];
  logic [ADDR_W-1:0]  m_addr  [16];
  logic [BURST_W-1:0] m_burst [16];
  logic [DATA_W-1:0]  m_data  [16];
  logic [MASK_W-1:0]  m_mask  [16];
  int head = 0;
  int tail = 0;

  assign fifo_pop_ready = (tail != head);

  always @(posedge clk) begin
    if (fifo_pop_valid && fifo_pop_ready) begin
      fifo_cmd_type  <= m_type[head];
      fifo_addr      <= m_addr[head];
      fifo_burst_cnt <= m_burst[head];
      fifo_wt_data   <= m_data[head];
      fifo_wt_mask   <= m_mask[head];
      head           <= head + 1;
    end
  end

  task automatic push(input logic t, input logic [ADDR_W-1:0] a, input logic [BURST_W-1:0] b,
                      input logic [DATA_W-1:0] d, input logic [MASK_W-1:0] m);
    m_type[tail] = t;
    m_addr[tail] = a;
    m_burst[tail] = b;
    m_data[tail] = d;
    m_mask[tail] = m;
    tail = tail + 1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cmd_en(input string tag, input int max_cyc);
    int n = 0;
    while (app_cmd_en !== 1'b1 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 128'(app_cmd_en), 128'd1);
  endtask

  localparam logic [DATA_W-1:0] D_W1 = {16{8'hA5}};
  localparam logic [DATA_W-1:0] D_W2 = {8{16'h1234}};
  localparam logic [DATA_W-1:0] D_W4 = {4{32'hCAFE_F00D}};

  initial begin
    int n_acc;
    logic early;
    rstn = 1'b0;
    calib_done = 1'b0;
    app_cmd_rdy = 1'b0;
    app_wdata_rdy = 1'b0;
    app_rdata_valid = 1'b0;
    app_rdata = '0;
    push(1'b1, 27'h0001000, 6'd0, D_W1, 16'h000F);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);

    // 1: calib low with FIFO non-empty: idle, no pop
    chk("rst_pop_valid", 128'(fifo_pop_valid), 0);
    chk("rst_cmd_en", 128'(app_cmd_en), 0);
    chk("rst_wdata_en", 128'(app_wdata_en), 0);
    chk("rst_busy", 128'(busy), 0);
    chk("rst_rd_valid", 128'(rd_valid), 0);
    chk("rst_addr", 128'(app_addr), 0);
    calib_done = 1'b1;
    app_cmd_rdy = 1'b1;
    app_wdata_rdy = 1'b1;
    @(negedge clk);
    chk("pop_1cyc", 128'(fifo_pop_valid), 1);
    @(negedge clk);
    chk("load_pop_valid", 128'(fifo_pop_valid), 0);
    chk("load_cmd_en", 128'(app_cmd_en), 0);

    // 2: single write, immediate rdy
    @(negedge clk);
    chk("w1_cmd_en", 128'(app_cmd_en), 1);
    chk("w1_wdata_en", 128'(app_wdata_en), 1);
    chk("w1_wdata_end", 128'(app_wdata_end), 1);
    chk("w1_cmd", 128'(app_cmd), 0);
    chk("w1_addr", 128'(app_addr), 128'h0001000);
    chk("w1_burst", 128'(app_burst_number), 0);
    chk("w1_wdata", 128'(app_wdata), 128'(D_W1));
    chk("w1_mask", 128'(app_wdata_mask), 128'h000F);
    @(negedge clk);
    chk("w1_done_cmd_en", 128'(app_cmd_en), 0);
    chk("w1_done_wdata_en", 128'(app_wdata_en), 0);
    chk("w1_refetch", 128'(fifo_pop_valid), 1);

    // 3: command accepted 3 cycles before data
    app_wdata_rdy = 1'b0;
    push(1'b1, 27'h0002340, 6'd0, D_W2, 16'hF000);
    wait_cmd_en("w2_cmd_en_wait", 10);
    chk("w2_wdata_en", 128'(app_wdata_en), 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("w2_cmd_en_dropped", 128'(app_cmd_en), 0);
      chk("w2_wdata_en_held", 128'(app_wdata_en), 1);
      chk("w2_wdata_stable", 128'(app_wdata), 128'(D_W2));
      chk("w2_mask_stable", 128'(app_wdata_mask), 128'hF000);
    end
    app_wdata_rdy = 1'b1;
    @(negedge clk);
    chk("w2_wdata_en_done", 128'(app_wdata_en), 0);
    chk("w2_refetch", 128'(fifo_pop_valid), 1);

    // 4: read burst 7, eight beats
    push(1'b0, 27'h0100000, 6'd7, '0, '0);
    wait_cmd_en("r1_cmd_en_wait", 10);
    chk("r1_cmd", 128'(app_cmd), 1);
    chk("r1_burst", 128'(app_burst_number), 7);
    chk("r1_addr", 128'(app_addr), 128'h0100000);
    chk("r1_wdata_en", 128'(app_wdata_en), 0);
    @(negedge clk);
    chk("r1_outstanding_8", 128'(u_dut.rd_outstanding), 8);
    chk("r1_cmd_en_dropped", 128'(app_cmd_en), 0);
    for (int i = 0; i < 8; i++) begin
      app_rdata_valid = 1'b1;
      app_rdata = 128'h0DD0_0000 + 128'(i);
      @(negedge clk);
      chk("r1_rd_valid", 128'(rd_valid), 1);
      chk("r1_rd_data", rd_data, 128'h0DD0_0000 + 128'(i));
      chk("r1_rd_last", 128'(rd_last), (i == 7) ? 128'd1 : 128'd0);
    end
    app_rdata_valid = 1'b0;
    @(negedge clk);
    chk("r1_outstanding_0", 128'(u_dut.rd_outstanding), 0);
    chk("r1_rd_valid_off", 128'(rd_valid), 0);
    calib_done = 1'b0;
    @(negedge clk);
    chk("calib_low_idle_busy", 128'(busy), 0);
    chk("calib_low_no_pop", 128'(fifo_pop_valid), 0);
    // stray beat with nothing outstanding
    app_rdata_valid = 1'b1;
    app_rdata = 128'h5A5A;
    @(negedge clk);
    app_rdata_valid = 1'b0;
    chk("stray_rd_valid", 128'(rd_valid), 1);
    chk("stray_rd_last", 128'(rd_last), 0);
    chk("stray_outstanding", 128'(u_dut.rd_outstanding), 0);
    calib_done = 1'b1;

    // 5: three reads of 8 beats against a 16-beat ceiling
    push(1'b0, 27'h0200000, 6'd7, '0, '0);
    push(1'b0, 27'h0200100, 6'd7, '0, '0);
    push(1'b0, 27'h0200200, 6'd7, '0, '0);
    n_acc = 0;
    for (int i = 0; i < 20; i++) begin
      if (app_cmd_en && app_cmd_rdy) n_acc++;
      @(negedge clk);
    end
    chk("r3_accepted_two", 128'(n_acc), 2);
    chk("r3_stalled_cmd_en", 128'(app_cmd_en), 0);
    chk("r3_outstanding_16", 128'(u_dut.rd_outstanding), 16);
    chk("r3_stalled_addr", 128'(app_addr), 128'h0200200);
    early = 1'b0;
    for (int i = 0; i < 8; i++) begin
      app_rdata_valid = 1'b1;
      app_rdata = 128'hB000 + 128'(i);
      @(negedge clk);
      if (app_cmd_en) early = 1'b1;
      chk("r3_first_rd_last", 128'(rd_last), (i == 7) ? 128'd1 : 128'd0);
    end
    app_rdata_valid = 1'b0;
    chk("r3_no_early_issue", 128'(early), 0);
    wait_cmd_en("r3_cmd_en_wait", 5);
    chk("r3_addr", 128'(app_addr), 128'h0200200);
    chk("r3_burst", 128'(app_burst_number), 7);
    @(negedge clk);
    chk("r3_outstanding_refill", 128'(u_dut.rd_outstanding), 16);
    for (int i = 0; i < 16; i++) begin
      app_rdata_valid = 1'b1;
      app_rdata = 128'hC000 + 128'(i);
      @(negedge clk);
      chk("r3_tail_rd_last", 128'(rd_last), (i % 8 == 7) ? 128'd1 : 128'd0);
    end
    app_rdata_valid = 1'b0;
    @(negedge clk);
    chk("r3_outstanding_0", 128'(u_dut.rd_outstanding), 0);

    // 6: reset during ISSUE_WR abandons the write
    app_cmd_rdy = 1'b0;
    app_wdata_rdy = 1'b0;
    push(1'b1, 27'h0300000, 6'd0, {8{16'hDEAD}}, 16'h00FF);
    push(1'b1, 27'h0400000, 6'd0, D_W4, 16'h0F0F);
    wait_cmd_en("w3_cmd_en_wait", 10);
    chk("w3_addr", 128'(app_addr), 128'h0300000);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("mid_rst_cmd_en", 128'(app_cmd_en), 0);
    chk("mid_rst_wdata_en", 128'(app_wdata_en), 0);
    chk("mid_rst_pop_valid", 128'(fifo_pop_valid), 0);
    chk("mid_rst_busy", 128'(busy), 0);
    chk("mid_rst_addr", 128'(app_addr), 0);
    chk("mid_rst_wdata", app_wdata, 0);
    @(negedge clk);
    rstn = 1'b1;
    app_cmd_rdy = 1'b1;
    app_wdata_rdy = 1'b1;
    wait_cmd_en("w4_cmd_en_wait", 10);
    chk("w4_addr", 128'(app_addr), 128'h0400000);
    chk("w4_wdata", app_wdata, 128'(D_W4));
    chk("w4_mask", 128'(app_wdata_mask), 128'h0F0F);
    @(negedge clk);
    chk("w4_done", 128'(app_wdata_en), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
